// File: rtl/symbol_sync.sv
// Symbol timing recovery: picks the sampling phase with the largest summed
// magnitude over an acquisition window, then decimates on that phase.
module symbol_sync #(
  parameter int NB_DATA = 8,
  parameter int S_NCON  = 4,
  parameter int NB_WIN  = 7
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_resync,
  input  logic signed [NB_DATA-1:0]   i_sample,
  output logic signed [NB_DATA-1:0]   o_data,
  output logic                        o_valid,
  output logic                        o_lock,
  output logic [$clog2(S_NCON)-1:0]   o_phase
);

  localparam int NB_PH  = $clog2(S_NCON);
  localparam int NB_ACC = NB_DATA + NB_WIN;

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_DECIDE, ST_TRACK} state_t;

  state_t                     state_q, state_d;
  logic [NB_PH-1:0]           ph_q, ph_d;
  logic [NB_WIN-1:0]          sym_q, sym_d;
  logic [NB_ACC-1:0]          acc_q [S_NCON];
  logic [NB_ACC-1:0]          acc_d [S_NCON];
  logic signed [NB_DATA-1:0]  data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       lock_q, lock_d;
  logic [NB_PH-1:0]           phase_q, phase_d;

  logic [NB_DATA-1:0]         mag;
  logic [NB_PH-1:0]           best_idx;
  logic [NB_ACC-1:0]          best_val;

  // Most negative input maps to 2^(NB_DATA-1) as an unsigned magnitude.
  always_comb begin
    mag = i_sample[NB_DATA-1] ? $unsigned(-i_sample) : $unsigned(i_sample);
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc_q[0];
    for (int unsigned i = 1; i < S_NCON; i++) begin
      if (acc_q[i] > best_val) begin
        best_val = acc_q[i];
        best_idx = NB_PH'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sym_d   = sym_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    phase_d = phase_q;

    if (i_resync) begin
      state_d = ST_IDLE;
      ph_d    = '0;
      sym_d   = '0;
      acc_d   = '{default: '0};
      lock_d  = 1'b0;
    end else if (i_enable) begin
      ph_d = ph_q + NB_PH'(1);
      unique case (state_q)
        ST_IDLE: begin
          acc_d[ph_q] = acc_q[ph_q] + NB_ACC'(mag);
          state_d     = ST_ACQ;
        end
        ST_ACQ: begin
          acc_d[ph_q] = acc_q[ph_q] + NB_ACC'(mag);
          if (ph_q == NB_PH'(S_NCON - 1)) begin
            sym_d = sym_q + NB_WIN'(1);
            if (sym_q == '1) begin
              state_d = ST_DECIDE;
            end
          end
        end
        ST_DECIDE: begin
          phase_d = best_idx;
          lock_d  = 1'b1;
          acc_d   = '{default: '0};
          sym_d   = '0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (ph_q == phase_q) begin
            data_d  = i_sample;
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      sym_q   <= '0;
      acc_q   <= '{default: '0};
      data_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sym_q   <= sym_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      phase_q <= phase_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_lock  = lock_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_symbol_sync.sv
// Randomized bench for symbol_sync with a stream-level reference model:
// enabled samples are numbered from each restart and judged by that index.
module tb_symbol_sync;

  localparam int NB_DATA = 8;
  localparam int S_NCON  = 4;
  localparam int NB_WIN  = 2;
  localparam int WIN     = S_NCON * (1 << NB_WIN);
  localparam int WIN_W   = S_NCON * (1 << 7);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                      i_reset = 1'b1;
  logic                      en = 1'b0, rs = 1'b0;
  logic signed [NB_DATA-1:0] smp = '0;
  logic signed [NB_DATA-1:0] o_data;
  logic                      o_valid, o_lock;
  logic [1:0]                o_phase;

  logic                      w_en = 1'b0, w_rs = 1'b0;
  logic signed [NB_DATA-1:0] w_smp = '0;
  logic signed [NB_DATA-1:0] w_data;
  logic                      w_valid, w_lock;
  logic [1:0]                w_phase;

  int n_checks = 0;
  int n_errors = 0;

  symbol_sync #(.NB_DATA(NB_DATA), .S_NCON(S_NCON), .NB_WIN(NB_WIN)) u_dut (
    .clock(clock), .i_reset(i_reset), .i_enable(en), .i_resync(rs),
    .i_sample(smp), .o_data(o_data), .o_valid(o_valid), .o_lock(o_lock),
    .o_phase(o_phase)
  );

  symbol_sync #(.NB_DATA(NB_DATA), .S_NCON(S_NCON), .NB_WIN(7)) u_wide (
    .clock(clock), .i_reset(i_reset), .i_enable(w_en), .i_resync(w_rs),
    .i_sample(w_smp), .o_data(w_data), .o_valid(w_valid), .o_lock(w_lock),
    .o_phase(w_phase)
  );

  // Reference model state
  int                        m_k;
  int                        m_sum [S_NCON];
  logic                      m_lock, m_valid;
  logic [1:0]                m_phase;
  logic signed [NB_DATA-1:0] m_data;

  function automatic int absval(input logic signed [NB_DATA-1:0] s);
    return (s < 0) ? -int'(s) : int'(s);
  endfunction

  function automatic logic signed [NB_DATA-1:0] rnd_signed(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    if ($urandom_range(1, 0) == 1) v = -v;
    return v[NB_DATA-1:0];
  endfunction

  task automatic model_reset();
    m_k = 0;
    foreach (m_sum[i]) m_sum[i] = 0;
    m_lock = 1'b0; m_valid = 1'b0; m_phase = '0; m_data = '0;
  endtask

  task automatic model_step(input logic e, input logic r, input logic signed [NB_DATA-1:0] s);
    int best;
    m_valid = 1'b0;
    if (r) begin
      m_k = 0;
      foreach (m_sum[i]) m_sum[i] = 0;
      m_lock = 1'b0;
    end else if (e) begin
      if (m_k < WIN) begin
        m_sum[m_k % S_NCON] += absval(s);
      end else if (m_k == WIN) begin
        best = 0;
        for (int i = 1; i < S_NCON; i++) if (m_sum[i] > m_sum[best]) best = i;
        m_phase = best[1:0];
        m_lock  = 1'b1;
      end else if ((m_k % S_NCON) == int'(m_phase)) begin
        m_valid = 1'b1;
        m_data  = s;
      end
      m_k++;
    end
  endtask

  task automatic step(input logic e, input logic r, input logic signed [NB_DATA-1:0] s);
    en = e; rs = r; smp = s;
    @(posedge clock);
    model_step(e, r, s);
    #1;
  endtask

  task automatic wstep(input logic e, input logic r, input logic signed [NB_DATA-1:0] s);
    w_en = e; w_rs = r; w_smp = s;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2 i_reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_lock !== 1'b0) begin n_errors++; $display("FAIL reset_lock: got %b want 0", o_lock); end
    n_checks++; if (o_phase !== 2'd0) begin n_errors++; $display("FAIL reset_phase: got %0d want 0", o_phase); end
    n_checks++; if (o_data !== 8'sd0) begin n_errors++; $display("FAIL reset_data: got %0d want 0", o_data); end
    n_checks++; if (w_lock !== 1'b0 || w_valid !== 1'b0) begin n_errors++; $display("FAIL reset_wide: lock/valid %b/%b want 0/0", w_lock, w_valid); end
    #1 i_reset = 1'b1;
  endtask

  task automatic test_lock_timing();
    logic signed [NB_DATA-1:0] s;
    for (int e = 1; e <= 40; e++) begin
      s = (((e - 1) % S_NCON) == 2) ? 8'sd100 : 8'sd10;
      step(1'b1, 1'b0, s);
      n_checks++;
      if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
        n_errors++;
        $display("FAIL lock_timing edge %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 e, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
      end
      if (e == 16) begin
        n_checks++; if (o_lock !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %b want 0 at edge 16", o_lock); end
      end
      if (e == 17) begin
        n_checks++;
        if (o_lock !== 1'b1 || o_phase !== 2'd2) begin n_errors++; $display("FAIL lock_edge17: lock/phase %b/%0d want 1/2", o_lock, o_phase); end
      end
      if (e == 19) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 8'sd100) begin n_errors++; $display("FAIL first_symbol: valid/data %b/%0d want 1/100", o_valid, o_data); end
      end
    end
  endtask

  task automatic test_ties();
    logic signed [NB_DATA-1:0] s;
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 1'b1, 8'sd0);
      for (int e = 0; e <= WIN; e++) begin
        if (pass == 0) s = 8'sd50;
        else           s = ((e % S_NCON) == 1) ? -8'sd128 : 8'sd127;
        step(1'b1, 1'b0, s);
        n_checks++;
        if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
          n_errors++;
          $display("FAIL ties pass %0d edge %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                   pass, e, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
        end
      end
      n_checks++;
      if (o_lock !== 1'b1 || o_phase !== ((pass == 0) ? 2'd0 : 2'd1)) begin
        n_errors++;
        $display("FAIL tie_rule pass %0d: lock/phase %b/%0d want 1/%0d", pass, o_lock, o_phase, pass);
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic signed [NB_DATA-1:0] s;
    logic e;
    int   n_en;
    bit   seen_lock;
    step(1'b0, 1'b1, 8'sd0);
    n_en = 0;
    seen_lock = 1'b0;
    for (int c = 0; c < 80; c++) begin
      e = (c % 2 == 0);
      if (!e)                        s = 8'sd127;
      else if ((m_k % S_NCON) == 3)  s = rnd_signed(90, 127);
      else                           s = rnd_signed(0, 30);
      step(e, 1'b0, s);
      if (e) n_en++;
      n_checks++;
      if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
        n_errors++;
        $display("FAIL enable_toggle cycle %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 c, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
      end
      if (!e && o_valid !== 1'b0) begin
        n_checks++; n_errors++;
        $display("FAIL valid_in_gap cycle %0d: got %b want 0", c, o_valid);
      end
      if (o_lock === 1'b1 && !seen_lock) begin
        seen_lock = 1'b1;
        n_checks++;
        if (n_en !== WIN + 1) begin n_errors++; $display("FAIL toggle_lock_count: enabled edges %0d want %0d", n_en, WIN + 1); end
      end
    end
    n_checks++;
    if (!seen_lock || o_phase !== 2'd3) begin
      n_errors++;
      $display("FAIL toggle_phase: lock_seen/phase %0d/%0d want 1/3", seen_lock, o_phase);
    end
  endtask

  task automatic test_resync_track();
    logic signed [NB_DATA-1:0] s;
    step(1'b1, 1'b1, 8'sd77);
    n_checks++;
    if (o_lock !== 1'b0 || o_valid !== 1'b0 || o_phase !== 2'd3) begin
      n_errors++;
      $display("FAIL resync_track: lock/valid/phase %b/%b/%0d want 0/0/3", o_lock, o_valid, o_phase);
    end
    for (int e = 0; e < 28; e++) begin
      s = ((e % S_NCON) == 1) ? rnd_signed(100, 127) : rnd_signed(0, 20);
      step(1'b1, 1'b0, s);
      n_checks++;
      if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
        n_errors++;
        $display("FAIL reacquire edge %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 e, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
      end
    end
    n_checks++;
    if (o_lock !== 1'b1 || o_phase !== 2'd1) begin
      n_errors++;
      $display("FAIL reacquire_phase: lock/phase %b/%0d want 1/1", o_lock, o_phase);
    end
  endtask

  task automatic test_reset_mid_acq();
    logic signed [NB_DATA-1:0] s;
    step(1'b0, 1'b1, 8'sd0);
    for (int e = 0; e < 7; e++) step(1'b1, 1'b0, rnd_signed(0, 127));
    #2 i_reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (o_lock !== 1'b0 || o_valid !== 1'b0 || o_phase !== 2'd0 || o_data !== 8'sd0) begin
      n_errors++;
      $display("FAIL async_reset: v/l/p/d %b/%b/%0d/%0d want 0/0/0/0", o_valid, o_lock, o_phase, o_data);
    end
    #1 i_reset = 1'b1;
    for (int e = 1; e <= WIN + 6; e++) begin
      s = (((e - 1) % S_NCON) == 2) ? rnd_signed(100, 127) : rnd_signed(0, 20);
      step(1'b1, 1'b0, s);
      n_checks++;
      if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
        n_errors++;
        $display("FAIL post_reset edge %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 e, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
      end
      if (e == WIN) begin
        n_checks++; if (o_lock !== 1'b0) begin n_errors++; $display("FAIL post_reset_early: lock %b want 0", o_lock); end
      end
      if (e == WIN + 1) begin
        n_checks++;
        if (o_lock !== 1'b1 || o_phase !== 2'd2) begin n_errors++; $display("FAIL post_reset_lock: lock/phase %b/%0d want 1/2", o_lock, o_phase); end
      end
    end
  endtask

  task automatic test_random();
    logic                      e, r;
    logic signed [NB_DATA-1:0] s;
    int                        dom;
    for (int it = 0; it < 6; it++) begin
      step(1'b0, 1'b1, 8'sd0);
      dom = int'($urandom_range(S_NCON - 1, 0));
      for (int c = 0; c < 90; c++) begin
        e = ($urandom_range(3, 0) != 0);
        r = ($urandom_range(59, 0) == 0);
        if (it >= 4)                       s = $urandom_range(255, 0);
        else if ((m_k % S_NCON) == dom)    s = rnd_signed(60, 128);
        else                               s = rnd_signed(0, 70);
        step(e, r, s);
        n_checks++;
        if (o_lock !== m_lock || o_valid !== m_valid || o_phase !== m_phase || o_data !== m_data) begin
          n_errors++;
          $display("FAIL random it %0d cycle %0d: v/l/p/d %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                   it, c, o_valid, o_lock, o_phase, o_data, m_valid, m_lock, m_phase, m_data);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic signed [NB_DATA-1:0] s;
    for (int pass = 0; pass < 2; pass++) begin
      wstep(1'b0, 1'b1, 8'sd0);
      for (int k = 0; k <= WIN_W + 4; k++) begin
        if (pass == 1 || (k % S_NCON) == 0) s = -8'sd128;
        else                                s = -8'sd127;
        wstep(1'b1, 1'b0, s);
        if (k == WIN_W - 1) begin
          n_checks++; if (w_lock !== 1'b0) begin n_errors++; $display("FAIL wide_early pass %0d: lock %b want 0", pass, w_lock); end
        end
        if (k == WIN_W) begin
          n_checks++;
          if (w_lock !== 1'b1 || w_phase !== 2'd0) begin
            n_errors++; $display("FAIL wide_phase pass %0d: lock/phase %b/%0d want 1/0", pass, w_lock, w_phase);
          end
        end
        if (k > WIN_W) begin
          n_checks++;
          if (w_valid !== ((k % S_NCON) == 0) || ((k % S_NCON) == 0 && w_data !== -8'sd128)) begin
            n_errors++; $display("FAIL wide_decim pass %0d k %0d: valid/data %b/%0d want %0d/-128", pass, k, w_valid, w_data, (k % S_NCON) == 0);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_ties();
    test_enable_toggle();
    test_resync_track();
    test_reset_mid_acq();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
